// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive FSMs.
// Covers the state encoding, the parity-type constants and the frame-length helper.
// Build macro: UART_TX_TWO_STOP_EN selects two stop bits instead of one.
package uart_pkg;

  // Frame states, 3-bit encoding; codes 5..7 are illegal and recover to IDLE
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  // Line cycles per frame: start + payload + optional parity + stop bit(s)
  function automatic int frame_cycles(input int data_width, input logic par_en);
    return data_width + 1 + STOP_BITS + (par_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload datapath for the UART transmitter. It holds the shift register, the bit
// counter and the parity bit. The parity bit is computed once, when the byte is
// loaded. The FSM drives the load, shift and counter-clear controls.
// rst is asynchronous and active-low, matching the top-level RST.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  cnt_clr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  ser_bit,
  output logic                  ser_done,
  output logic                  par_bit
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  par_reg;

  // Load the byte and its parity on accept; shift out one bit each time the line consumes one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      par_reg   <= 1'b0;
    end else if (load) begin
      shift_reg <= data;
      par_reg   <= (^data) ^ par_typ;
    end else if (shift) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  // Counter tracks the data bit on the line; the FSM stops shifting at the last bit so it never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load || cnt_clr) begin
      cnt_reg <= '0;
    end else if (shift) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign ser_bit  = shift_reg[0];
  assign ser_done = (cnt_reg == CNT_W'(DATA_WIDTH - 1));
  assign par_bit  = par_reg;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter frame FSM. One bit is sent per CLK cycle, in this order:
// start, data LSB-first, optional parity, then stop.
// TX_OUT and busy come straight from flops that are loaded from the next state,
// so the line never sees a combinational glitch.
// Build macro: UART_TX_TWO_STOP_EN adds a second stop cycle. Accept then moves to that second stop cycle.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  uart_state_e state_reg, state_next;
  logic        tx_reg, tx_next;
  logic        busy_reg;
  logic        par_en_reg;
  logic        accept, last_stop;
  logic        shift, cnt_clr;
  logic        ser_bit, ser_done, par_bit;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt_reg, stop_cnt_next;

  // Second stop cycle is the only one that may hand over to a new frame
  always_comb begin
    stop_cnt_next = (state_reg == STOP) && !stop_cnt_reg;
  end

  // Stop counter register: 0 on the first stop cycle, 1 on the second
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) stop_cnt_reg <= 1'b0;
    else      stop_cnt_reg <= stop_cnt_next;
  end

  assign last_stop = stop_cnt_reg;
`else
  assign last_stop = 1'b1;
`endif

  // Accept window is idle or the final stop cycle, which allows back-to-back frames
  assign accept = Data_Valid && ((state_reg == IDLE) || ((state_reg == STOP) && last_stop));

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .shift    (shift),
    .cnt_clr  (cnt_clr),
    .data     (P_DATA),
    .par_typ  (PAR_TYP),
    .ser_bit  (ser_bit),
    .ser_done (ser_done),
    .par_bit  (par_bit)
  );

  // Next-state logic; shift fires on each edge that puts a new data bit onto the line
  always_comb begin
    state_next = IDLE;
    shift      = 1'b0;
    cnt_clr    = 1'b0;
    case (state_reg)
      IDLE:   state_next = accept ? START : IDLE;
      START: begin
        state_next = DATA;
        shift      = 1'b1;
        cnt_clr    = 1'b1;
      end
      DATA: begin
        if (ser_done) begin
          state_next = par_en_reg ? PARITY : STOP;
        end else begin
          state_next = DATA;
          shift      = 1'b1;
        end
      end
      PARITY: state_next = STOP;
      STOP: begin
        if (accept)          state_next = START;
        else if (!last_stop) state_next = STOP;
        else                 state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output mux: the line level that belongs to the upcoming state, registered below
  always_comb begin
    tx_next = IDLE_LEVEL;
    case (state_next)
      START:   tx_next = ~IDLE_LEVEL;
      DATA:    tx_next = ser_bit;
      PARITY:  tx_next = par_bit;
      default: tx_next = IDLE_LEVEL;
    endcase
  end

  // State, output flops and parity enable latched at accept; reset abandons any frame in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= IDLE;
      tx_reg     <= IDLE_LEVEL;
      busy_reg   <= 1'b0;
      par_en_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tx_reg    <= tx_next;
      busy_reg  <= (state_next != IDLE);
      if (accept) par_en_reg <= PAR_EN;
    end
  end

  assign TX_OUT = tx_reg;
  assign busy   = busy_reg;

endmodule
